// File: rtl/mux_rr_arb.sv
// rtl/mux_rr_arb.sv - N-input registered mux with round-robin or fixed-priority arbitration
// One-entry output register; src_ready is a single combinational grant gated by load.
module mux_rr_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] src,
  input  logic [N-1:0]       src_valid,
  output logic [N-1:0]       src_ready,
  input  logic               mode,
  output logic [WIDTH-1:0]   z,
  output logic [SELW-1:0]    z_sel,
  output logic               z_valid,
  input  logic               z_ready
);

  logic [WIDTH-1:0] z_q, z_d;
  logic [SELW-1:0]  z_sel_q, z_sel_d;
  logic             z_valid_q, z_valid_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             load;
  logic             grant;
  logic             grant_found;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  cand_idx;
  int               cand;

  assign load = !z_valid_q || z_ready;

  // Fixed priority scans 0..N-1; round-robin scans last+1 .. last+N modulo N.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < N; k++) begin
      cand     = mode ? ((int'(last_q) + 1 + k) % N) : k;
      cand_idx = cand[SELW-1:0];
      if (!grant_found && src_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign grant = rst_n && load && grant_found;

  always_comb begin
    src_ready = '0;
    if (grant) begin
      src_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    z_d       = z_q;
    z_sel_d   = z_sel_q;
    z_valid_d = z_valid_q;
    last_d    = last_q;
    if (grant) begin
      for (int i = 0; i < N; i++) begin
        if (grant_idx == i[SELW-1:0]) begin
          z_d = src[i*WIDTH +: WIDTH];
        end
      end
      z_sel_d   = grant_idx;
      z_valid_d = 1'b1;
      last_d    = grant_idx;
    end else if (load) begin
      z_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q       <= '0;
      z_sel_q   <= '0;
      z_valid_q <= 1'b0;
      last_q    <= SELW'(N - 1);
    end else begin
      z_q       <= z_d;
      z_sel_q   <= z_sel_d;
      z_valid_q <= z_valid_d;
      last_q    <= last_d;
    end
  end

  assign z       = z_q;
  assign z_sel   = z_sel_q;
  assign z_valid = z_valid_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb/tb_mux_rr_arb.sv - self-checking bench for mux_rr_arb with WIDTH=8, N=4
module tb_mux_rr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src;
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;
  logic        mode;
  logic [7:0]  z;
  logic [1:0]  z_sel;
  logic        z_valid;
  logic        z_ready;

  logic [7:0]  d [4];

  int checks   = 0;
  int failures = 0;

  logic [7:0]  m_z;
  int          m_sel;
  int          m_last;
  logic        m_zv;
  logic [3:0]  m_xfer;

  mux_rr_arb #(.WIDTH(8), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (src),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .mode      (mode),
    .z         (z),
    .z_sel     (z_sel),
    .z_valid   (z_valid),
    .z_ready   (z_ready)
  );

  always #5 clk = ~clk;

  always_comb src = {d[3], d[2], d[1], d[0]};

  function automatic logic [3:0] exp_ready(input logic [3:0] v, input logic md, input int last,
                                           input logic zv, input logic zr, input logic rn);
    if (!rn || (zv && !zr)) return 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = md ? ((last + k) % 4) : (k - 1);
      if (v[c]) return 4'b0001 << c;
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_z    = 8'h00;
    m_sel  = 0;
    m_zv   = 1'b0;
    m_last = 3;
  endtask

  task automatic set_fixed_data();
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
  endtask

  task automatic tick();
    logic [3:0] r;
    r = exp_ready(src_valid, mode, m_last, m_zv, z_ready, rst_n);
    @(posedge clk);
    m_xfer = r;
    if (rst_n) begin
      if (r != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (r[k]) begin
            m_sel = k;
            m_z   = d[k];
          end
        end
        m_last = m_sel;
        m_zv   = 1'b1;
      end else if (!m_zv || z_ready) begin
        m_zv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; z_ready = 1'b1; src_valid = 4'b1111;
    set_fixed_data();
    model_reset();
    #2;
    checks++; if (src_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready_low got=%b exp=0000", src_ready); end
    checks++; if (z_valid !== 1'b0) begin failures++; $display("FAIL rst_zvalid got=%b exp=0", z_valid); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (src_ready !== 4'b0001) begin failures++; $display("FAIL rst_first_grant got=%b exp=0001", src_ready); end
    tick();
    checks++; if (z_sel !== 2'd0 || z !== 8'h11 || z_valid !== 1'b1) begin
      failures++; $display("FAIL rst_first_word got=%0d/%h/%b exp=0/11/1", z_sel, z, z_valid); end
    tick();
    @(negedge clk); rst_n = 1'b0; model_reset(); #1;
    checks++; if (z !== 8'h00 || z_sel !== 2'd0 || z_valid !== 1'b0) begin
      failures++; $display("FAIL rst_async_out got=%h/%0d/%b exp=00/0/0", z, z_sel, z_valid); end
    checks++; if (src_ready !== 4'b0000) begin failures++; $display("FAIL rst_async_ready got=%b exp=0000", src_ready); end
    tick();
    checks++; if (z_valid !== 1'b0) begin failures++; $display("FAIL rst_hold_edge got=%b exp=0", z_valid); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (src_ready !== 4'b0001) begin failures++; $display("FAIL rst_rr_restart got=%b exp=0001", src_ready); end
    tick();
    checks++; if (z_sel !== 2'd0) begin failures++; $display("FAIL rst_rr_restart_sel got=%0d exp=0", z_sel); end
  endtask

  task automatic test_single();
    set_fixed_data();
    apply_reset();
    mode = 1'b0; z_ready = 1'b1; src_valid = 4'b0100;
    #1;
    checks++; if (src_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", src_ready); end
    tick();
    src_valid = 4'b0000;
    #1;
    checks++; if (z !== 8'h33 || z_sel !== 2'd2 || z_valid !== 1'b1) begin
      failures++; $display("FAIL single_word got=%h/%0d/%b exp=33/2/1", z, z_sel, z_valid); end
    checks++; if (src_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_drop got=%b exp=0000", src_ready); end
    tick();
    checks++; if (z_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", z_valid); end
  endtask

  task automatic test_rr_wrap();
    logic [1:0] es [6];
    logic [7:0] ez [6];
    es = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    ez = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
    set_fixed_data();
    apply_reset();
    mode = 1'b1; z_ready = 1'b1; src_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (z_sel !== es[i] || z !== ez[i] || z_valid !== 1'b1) begin
        failures++; $display("FAIL rr_wrap[%0d] got=%0d/%h exp=%0d/%h", i, z_sel, z, es[i], ez[i]); end
    end
  endtask

  task automatic test_fixed();
    logic [1:0] es [3];
    es = '{2'd2, 2'd3, 2'd1};
    set_fixed_data();
    apply_reset();
    mode = 1'b0; z_ready = 1'b1; src_valid = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (z_sel !== 2'd1 || z !== 8'h22) begin
        failures++; $display("FAIL fixed_prio[%0d] got=%0d/%h exp=1/22", i, z_sel, z); end
    end
    mode = 1'b1;
    #1;
    checks++; if (src_ready !== 4'b0100) begin failures++; $display("FAIL mode_switch_ready got=%b exp=0100", src_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (z_sel !== es[i]) begin failures++; $display("FAIL mode_switch[%0d] got=%0d exp=%0d", i, z_sel, es[i]); end
    end
  endtask

  task automatic test_backpressure();
    set_fixed_data();
    apply_reset();
    mode = 1'b1; z_ready = 1'b1; src_valid = 4'b1111;
    tick();
    tick();
    z_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (src_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, src_ready); end
      tick();
      checks++; if (z !== 8'h22 || z_sel !== 2'd1 || z_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold[%0d] got=%h/%0d/%b exp=22/1/1", i, z, z_sel, z_valid); end
    end
    z_ready = 1'b1;
    #1;
    checks++; if (src_ready !== 4'b0100) begin failures++; $display("FAIL bp_release got=%b exp=0100", src_ready); end
    tick();
    checks++; if (z_sel !== 2'd2 || z !== 8'h33) begin failures++; $display("FAIL bp_next got=%0d/%h exp=2/33", z_sel, z); end
  endtask

  task automatic test_sparse();
    set_fixed_data();
    apply_reset();
    mode = 1'b1; z_ready = 1'b1; src_valid = 4'b0100;
    #1;
    checks++; if (src_ready !== 4'b0100) begin failures++; $display("FAIL sparse_ready got=%b exp=0100", src_ready); end
    tick();
    checks++; if (z_sel !== 2'd2 || z !== 8'h33) begin failures++; $display("FAIL sparse_word got=%0d/%h exp=2/33", z_sel, z); end
  endtask

  task automatic test_random();
    logic [3:0] er;
    apply_reset();
    src_valid = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      z_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      for (int k = 0; k < 4; k++) begin
        if (!src_valid[k] && $urandom_range(0, 1) == 1) begin
          d[k] = 8'($urandom);
          src_valid[k] = 1'b1;
        end
      end
      #1;
      er = exp_ready(src_valid, mode, m_last, m_zv, z_ready, rst_n);
      checks++; if (src_ready !== er) begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, src_ready, er); end
      checks++; if (z_valid !== m_zv) begin failures++; $display("FAIL rand_zvalid[%0d] got=%b exp=%b", n, z_valid, m_zv); end
      if (m_zv) begin
        checks++; if (z !== m_z || z_sel !== m_sel[1:0]) begin
          failures++; $display("FAIL rand_word[%0d] got=%h/%0d exp=%h/%0d", n, z, z_sel, m_z, m_sel); end
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        if (m_xfer[k]) src_valid[k] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_wrap();
    test_fixed();
    test_backpressure();
    test_sparse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
